// File: rtl/rcv_control_if.sv
// rcv_control_if: serial pin, bit timer, shift register and host signals of the UART receive control
interface rcv_control_if;
  logic serial_in;
  logic shift_enable;
  logic packet_done;
  logic stop_bit;
  logic data_read;
  logic enable_timer;
  logic timer_clear;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;
  modport slave (
    input  serial_in, shift_enable, packet_done, stop_bit, data_read,
    output enable_timer, timer_clear, load_buffer, data_ready, framing_error, overrun_error
  );
  modport master (
    output serial_in, shift_enable, packet_done, stop_bit, data_read,
    input  enable_timer, timer_clear, load_buffer, data_ready, framing_error, overrun_error
  );
endinterface

// File: rtl/rcv_control.sv
// rcv_control: UART receive sequencer with start detect, stop check, buffer load and host flags
module rcv_control (
  input logic clk,
  input logic n_rst,
  rcv_control_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RECEIVE, CHECK, LOAD} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, prev_q, start_edge;
  logic en_q, clr_q, ld_q, dr_q, fe_q, oe_q;
  logic dr_d, fe_d, oe_d;
  logic is_check, is_load;
  logic unused_shift;
  assign unused_shift = bus.shift_enable;
  always_comb begin
    start_edge = prev_q & ~sync2_q;
    is_check = state_q == CHECK;
    is_load = state_q == LOAD;
    state_d = (state_q == IDLE)    ? (start_edge ? CLEAR : IDLE) :
              (state_q == CLEAR)   ? RECEIVE :
              (state_q == RECEIVE) ? (bus.packet_done ? CHECK : RECEIVE) :
              (state_q == CHECK)   ? (bus.stop_bit ? LOAD : IDLE) :
              IDLE;
    dr_d = is_load ? 1'b1 : bus.data_read ? 1'b0 : dr_q;
    oe_d = (is_load & dr_q & ~bus.data_read) ? 1'b1 : bus.data_read ? 1'b0 : oe_q;
    fe_d = (is_check & ~bus.stop_bit) ? 1'b1 : (state_q == CLEAR) ? 1'b0 : fe_q;
  end
  // strobes are registered from the next state so they track state_q exactly
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
      en_q <= 1'b0;
      clr_q <= 1'b0;
      ld_q <= 1'b0;
      dr_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.serial_in;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      en_q <= state_d == RECEIVE;
      clr_q <= state_d == CLEAR;
      ld_q <= state_d == LOAD;
      dr_q <= dr_d;
      fe_q <= fe_d;
      oe_q <= oe_d;
    end
  end
  assign bus.enable_timer = en_q;
  assign bus.timer_clear = clr_q;
  assign bus.load_buffer = ld_q;
  assign bus.data_ready = dr_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = oe_q;
endmodule
